// File: rtl/dieu_khien_tao_xung_pkg.sv
// Shared types and defaults for the square-wave sequencer, its button block and display.
// Optional tick output is enabled with `TAO_XUNG_TICK_EN (see dieu_khien_tao_xung).
package dieu_khien_tao_xung_pkg;

    localparam int unsigned FREQ_W       = 7;
    localparam int unsigned FREQ_MAX_DEF = 99;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV    = 2'd1,
        S_PEND   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    function automatic logic [FREQ_W-1:0] clamp_freq(
        input logic [FREQ_W-1:0] f,
        input logic [FREQ_W-1:0] f_max
    );
        return (f > f_max) ? f_max : f;
    endfunction

endpackage

// File: rtl/dieu_khien_tao_xung_if.sv
// Setpoint handshake between the button block (master) and the wave sequencer (slave).
interface dieu_khien_tao_xung_if;
    import dieu_khien_tao_xung_pkg::*;

    logic              cfg_req;
    logic [FREQ_W-1:0] cfg_freq;
    logic              cfg_ack;
    logic              busy;
    logic [FREQ_W-1:0] cur_freq;

    modport master (
        output cfg_req,
        output cfg_freq,
        input  cfg_ack,
        input  busy,
        input  cur_freq
    );

    modport slave (
        input  cfg_req,
        input  cfg_freq,
        output cfg_ack,
        output busy,
        output cur_freq
    );

endinterface

// File: rtl/dieu_khien_tao_xung_chia_tuan_tu.sv
// Sequential restoring divider: one quotient bit per cycle, done in the CNT_W-th cycle after start.
module chia_tuan_tu
    import dieu_khien_tao_xung_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic              main_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  dividend,
    input  logic [FREQ_W-1:0] divisor,
    output logic [CNT_W-1:0]  quotient,
    output logic              done
);

    localparam int unsigned STEP_W = $clog2(CNT_W + 1);

    logic [STEP_W-1:0] steps;
    logic [FREQ_W:0]   rem;
    logic [FREQ_W-1:0] dsr;
    logic [FREQ_W+1:0] trial;
    logic [FREQ_W+1:0] diff;

    // The dividend is shifted out of the quotient register MSB-first while quotient bits enter at the LSB.
    always_comb begin
        trial = {rem, quotient[CNT_W-1]};
        diff  = trial - {2'b00, dsr};
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            steps    <= '0;
            rem      <= '0;
            dsr      <= '0;
            quotient <= '0;
        end else if (start) begin
            steps    <= STEP_W'(CNT_W);
            rem      <= '0;
            dsr      <= divisor;
            quotient <= dividend;
        end else if (steps != '0) begin
            steps <= steps - STEP_W'(1);
            if (trial >= {2'b00, dsr}) begin
                rem      <= diff[FREQ_W:0];
                quotient <= {quotient[CNT_W-2:0], 1'b1};
            end else begin
                rem      <= trial[FREQ_W:0];
                quotient <= {quotient[CNT_W-2:0], 1'b0};
            end
        end
    end

    assign done = (steps == STEP_W'(1));

endmodule

// File: rtl/dieu_khien_tao_xung.sv
// Square-wave sequencer: accepts a setpoint, divides out the half-period, commits it glitch-free at a toggle.
// Define `TAO_XUNG_TICK_EN to get the tick_o rising-edge pulse output.
module dieu_khien_tao_xung
    import dieu_khien_tao_xung_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 27_000_000,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned FREQ_MAX = FREQ_MAX_DEF
) (
    input  logic                 main_clk,
    input  logic                 rst_n,
    dieu_khien_tao_xung_if.slave cfg,
    output logic                 wave_o
`ifdef TAO_XUNG_TICK_EN
    ,
    output logic                 tick_o
`endif
);

    localparam logic [CNT_W-1:0]  DIVIDEND = CNT_W'(CLK_HZ / 2);
    localparam logic [FREQ_W-1:0] F_CEIL   = FREQ_W'(FREQ_MAX);

    state_t            state;
    state_t            state_nx;
    logic [FREQ_W-1:0] f_lat;
    logic [FREQ_W-1:0] cur_freq_r;
    logic [CNT_W-1:0]  half_cnt;
    logic [CNT_W-1:0]  half_per;
    logic [CNT_W-1:0]  quot;
    logic [CNT_W-1:0]  h_new;
    logic              wave_r;
    logic              accept;
    logic              commit;
    logic              div_done;
    logic              running;
    logic              ack;
    logic              busy_c;

    chia_tuan_tu #(
        .CNT_W (CNT_W)
    ) u_chia (
        .main_clk (main_clk),
        .rst_n    (rst_n),
        .start    (accept),
        .dividend (DIVIDEND),
        .divisor  (clamp_freq(cfg.cfg_freq, F_CEIL)),
        .quotient (quot),
        .done     (div_done)
    );

    assign running = (cur_freq_r != '0);
    assign h_new   = (f_lat == '0) ? '0 : quot;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (accept) state_nx = S_DIV;
            S_DIV:    if (div_done) state_nx = (!running || f_lat == '0) ? S_COMMIT : S_PEND;
            S_PEND:   if (commit) state_nx = S_IDLE;
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // A pending change commits in the same cycle the generator toggles, so the reload already uses H_new.
    always_comb begin
        commit = (state == S_COMMIT) || (state == S_PEND && half_cnt == '0);
        ack    = commit;
        busy_c = (state != S_IDLE);
        accept = (state == S_IDLE) && cfg.cfg_req && !ack;
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            f_lat      <= '0;
            cur_freq_r <= '0;
            half_per   <= '0;
            half_cnt   <= '0;
            wave_r     <= 1'b0;
        end else begin
            if (accept) f_lat <= clamp_freq(cfg.cfg_freq, F_CEIL);
            if (commit) begin
                cur_freq_r <= f_lat;
                half_per   <= h_new;
                if (f_lat == '0) begin
                    wave_r   <= 1'b0;
                    half_cnt <= '0;
                end else begin
                    half_cnt <= h_new - CNT_W'(1);
                    if (running && half_cnt == '0) wave_r <= ~wave_r;
                end
            end else if (running) begin
                if (half_cnt == '0) begin
                    wave_r   <= ~wave_r;
                    half_cnt <= half_per - CNT_W'(1);
                end else begin
                    half_cnt <= half_cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef TAO_XUNG_TICK_EN
    logic tick_r;
    logic rise;

    always_comb begin
        rise = running && half_cnt == '0 && !wave_r && !(commit && f_lat == '0);
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) tick_r <= 1'b0;
        else        tick_r <= rise;
    end

    assign tick_o = tick_r;
`endif

    assign cfg.cfg_ack  = ack;
    assign cfg.busy     = busy_c;
    assign cfg.cur_freq = cur_freq_r;
    assign wave_o       = wave_r;

endmodule
